// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the sequential CORDIC engine.
package cordic_pkg;

    localparam int unsigned ATAN_W = 32;
    localparam int unsigned ATAN_N = 28;
    localparam int unsigned CNT_W  = 5;

    localparam logic signed [ATAN_W-1:0] K_GAIN = 32'sh09B74EDA;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // atan(2^-i) in Q4.28, rounded to nearest; from i=10 on it equals 2^(28-i) to within half an LSB
    function automatic logic signed [ATAN_W-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        logic signed [ATAN_W-1:0] a;
        a = '0;
        case (idx)
            5'd0:    a = 32'sh0C90FDAA;
            5'd1:    a = 32'sh076B19C1;
            5'd2:    a = 32'sd65760959;
            5'd3:    a = 32'sd33381290;
            5'd4:    a = 32'sd16755422;
            5'd5:    a = 32'sd8385879;
            5'd6:    a = 32'sd4193963;
            5'd7:    a = 32'sd2097109;
            5'd8:    a = 32'sd1048571;
            5'd9:    a = 32'sd524287;
            default: begin
                if (idx <= 5'd27) begin
                    a = ATAN_W'(1) << (5'd28 - idx);
                end
            end
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_iter_step.sv
// One CORDIC micro-rotation; purely combinational, time-shared across iterations.
module cordic_iter_step
    import cordic_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic signed [N-1:0]     x,
    input  logic signed [N-1:0]     y,
    input  logic signed [N-1:0]     z,
    input  logic        [CNT_W-1:0] i,
    input  logic                    mode,
    input  logic signed [N-1:0]     atan_i,
    output logic signed [N-1:0]     x_nxt_c,
    output logic signed [N-1:0]     y_nxt_c,
    output logic signed [N-1:0]     z_nxt_c
);

    logic                d_pos;
    logic signed [N-1:0] x_sh;
    logic signed [N-1:0] y_sh;

    // d=+1 drives Z toward zero (rotation) or Y toward zero (vectoring)
    always_comb begin
        d_pos = (mode == MODE_VEC) ? y[N-1] : ~z[N-1];
        x_sh  = x >>> i;
        y_sh  = y >>> i;
        if (d_pos) begin
            x_nxt_c = x - y_sh;
            y_nxt_c = y + x_sh;
            z_nxt_c = z - atan_i;
        end else begin
            x_nxt_c = x + y_sh;
            y_nxt_c = y - x_sh;
            z_nxt_c = z + atan_i;
        end
    end

endmodule

// File: rtl/cordic_seq.sv
// Iterative CORDIC engine: one micro-rotation per clock, then one gain-correction cycle,
// with valid/ready handshakes on both sides and no overlap between operations.
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned ITER = 16,
    parameter int unsigned FRAC = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_x,
    input  logic signed [N-1:0] in_y,
    input  logic signed [N-1:0] in_z,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_x,
    output logic signed [N-1:0] out_y,
    output logic signed [N-1:0] out_z
);

    localparam int unsigned         PW   = 2 * N;
    localparam logic signed [N-1:0] K    = N'(K_GAIN);
    localparam logic [CNT_W-1:0]    LAST = CNT_W'(ITER - 1);

    if (ITER < 1 || ITER > ATAN_N) begin : g_iter_range
        $error("cordic_seq: ITER must lie in 1..28");
    end

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic signed [N-1:0] x_r;
    logic signed [N-1:0] y_r;
    logic signed [N-1:0] z_r;
    logic                mode_r;
    logic signed [N-1:0] atan_c;
    logic signed [N-1:0] x_nxt_c;
    logic signed [N-1:0] y_nxt_c;
    logic signed [N-1:0] z_nxt_c;
    logic signed [PW-1:0] prod_x_c;
    logic signed [PW-1:0] prod_y_c;

    assign atan_c   = N'(atan_lut(cnt));
    assign prod_x_c = PW'(x_r) * PW'(K);
    assign prod_y_c = PW'(y_r) * PW'(K);

    cordic_iter_step #(
        .N (N)
    ) u_step (
        .x       (x_r),
        .y       (y_r),
        .z       (z_r),
        .i       (cnt),
        .mode    (mode_r),
        .atan_i  (atan_c),
        .x_nxt_c (x_nxt_c),
        .y_nxt_c (y_nxt_c),
        .z_nxt_c (z_nxt_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= cordic_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            cordic_pkg::IDLE:  if (in_valid && in_ready) state_nxt = cordic_pkg::ITER;
            cordic_pkg::ITER:  if (cnt == LAST)          state_nxt = cordic_pkg::SCALE;
            cordic_pkg::SCALE:                           state_nxt = cordic_pkg::DONE;
            cordic_pkg::DONE:  if (out_ready)            state_nxt = cordic_pkg::IDLE;
            default:                                     state_nxt = cordic_pkg::IDLE;
        endcase
    end

    // Accept only while idle and out of reset
    always_comb begin
        in_ready = 1'b0;
        if (state == cordic_pkg::IDLE && rst_n) begin
            in_ready = 1'b1;
        end
    end

    // Working registers, iteration counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            mode_r    <= MODE_ROT;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else begin
            case (state)
                cordic_pkg::IDLE: begin
                    if (in_valid) begin
                        x_r    <= in_x;
                        y_r    <= in_y;
                        z_r    <= in_z;
                        mode_r <= in_mode;
                        cnt    <= '0;
                    end
                end
                cordic_pkg::ITER: begin
                    x_r <= x_nxt_c;
                    y_r <= y_nxt_c;
                    z_r <= z_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                end
                cordic_pkg::SCALE: begin
                    out_x     <= N'(prod_x_c >>> FRAC);
                    out_y     <= N'(prod_y_c >>> FRAC);
                    out_z     <= z_r;
                    out_valid <= 1'b1;
                end
                cordic_pkg::DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq: hand-computed vector table plus handshake, reset and ITER corner sequences.
module tb_cordic_seq;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                in_valid;
    logic                out_ready;
    logic [1:0]          sel;
    logic signed [N-1:0] in_x, in_y, in_z;
    logic                in_mode;

    logic iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, or0, or1, or2;
    logic signed [N-1:0] ox0, oy0, oz0, ox1, oy1, oz1, ox2, oy2, oz2;
    logic                cur_ready, cur_valid;
    logic signed [N-1:0] cur_x, cur_y, cur_z;

    assign iv0 = in_valid && (sel == 2'd0);
    assign iv1 = in_valid && (sel == 2'd1);
    assign iv2 = in_valid && (sel == 2'd2);
    assign or0 = (sel == 2'd0) ? out_ready : 1'b1;
    assign or1 = (sel == 2'd1) ? out_ready : 1'b1;
    assign or2 = (sel == 2'd2) ? out_ready : 1'b1;

    always_comb begin
        cur_ready = ir0; cur_valid = ov0; cur_x = ox0; cur_y = oy0; cur_z = oz0;
        case (sel)
            2'd1: begin cur_ready = ir1; cur_valid = ov1; cur_x = ox1; cur_y = oy1; cur_z = oz1; end
            2'd2: begin cur_ready = ir2; cur_valid = ov2; cur_x = ox2; cur_y = oy2; cur_z = oz2; end
            default: ;
        endcase
    end

    cordic_seq #(.N(32), .ITER(16), .FRAC(28)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_mode(in_mode),
        .out_valid(ov0), .out_ready(or0), .out_x(ox0), .out_y(oy0), .out_z(oz0));

    cordic_seq #(.N(32), .ITER(1), .FRAC(28)) dut_i1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(or1), .out_x(ox1), .out_y(oy1), .out_z(oz1));

    cordic_seq #(.N(32), .ITER(28), .FRAC(28)) dut_i28 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_mode(in_mode),
        .out_valid(ov2), .out_ready(or2), .out_x(ox2), .out_y(oy2), .out_z(oz2));

    int     n_vec = 0;
    int     n_err = 0;
    longint atan_tb [28];

    typedef struct {
        logic signed [31:0] x, y, z;
        logic               m;
        logic signed [31:0] ex, ey, ez;
        int                 tx, ty, tz;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint diff;
        n_vec++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tolerance %0d)", name, act, exp, tol);
        end
    endtask

    // Reference algorithm with its own arctangent table derived from $atan
    function automatic void model(input logic signed [31:0] xi, yi, zi, input logic m, input int iters,
                                  output logic signed [31:0] xo, yo, zo);
        logic signed [31:0] x, y, z, xs, ys;
        logic signed [63:0] px, py;
        logic               dp;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < iters; i++) begin
            dp = m ? y[31] : ~z[31];
            xs = x >>> i;
            ys = y >>> i;
            if (dp) begin x = x - ys; y = y + xs; z = z - 32'(atan_tb[i]); end
            else    begin x = x + ys; y = y - xs; z = z + 32'(atan_tb[i]); end
        end
        px = 64'(x) * 64'sh09B74EDA;
        py = 64'(y) * 64'sh09B74EDA;
        xo = 32'(px >>> 28);
        yo = 32'(py >>> 28);
        zo = z;
    endfunction

    task automatic run_op(input logic signed [31:0] x, y, z, input logic m,
                          output logic signed [31:0] rx, ry, rz, output int lat, output logic rdy_after);
        int guard;
        out_ready = 1'b1;
        in_x = x; in_y = y; in_z = z; in_mode = m; in_valid = 1'b1;
        guard = 0;
        while (!cur_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = $urandom; in_y = $urandom; in_z = $urandom; in_mode = ~m;
        lat = 0;
        while (!cur_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        rx = cur_x; ry = cur_y; rz = cur_z;
        @(posedge clk); #1;
        rdy_after = cur_ready;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic signed [31:0] rx, ry, rz, mx, my, mz, cx, cy, cz;
        int   lat, guard;
        logic rdy, saw;

        for (int i = 0; i < 28; i++) atan_tb[i] = longint'($rtoi($atan(2.0 ** (-i)) * 268435456.0 + 0.5));

        vecs[0] = '{32'sh10000000, 32'sd0, 32'sh0C90FDAA, 1'b0, 32'sh0B504F33, 32'sh0B504F33, 32'sd0, 65536, 65536, 16384};
        vecs[1] = '{32'sh0999999A, 32'sh0CCCCCCD, 32'sd0, 1'b1, 32'sh10000000, 32'sd0, 32'sd248918915, 65536, 65536, 65536};
        vecs[2] = '{32'sh10000000, 32'sd0, 32'sd0, 1'b0, 32'sh10000000, 32'sd0, 32'sd0, 65536, 65536, 16384};
        vecs[3] = '{32'sh10000000, 32'sd0, 32'sd421657428, 1'b0, 32'sd0, 32'sh10000000, 32'sd0, 65536, 65536, 16384};
        vecs[4] = '{32'sd0, 32'sh10000000, -32'sd421657428, 1'b0, 32'sh10000000, 32'sd0, 32'sd0, 65536, 65536, 16384};
        vecs[5] = '{32'sh10000000, -32'sh10000000, 32'sd0, 1'b1, 32'sd379625062, 32'sd0, -32'sd210828714, 65536, 65536, 65536};
        vecs[6] = '{32'sh08000000, 32'sd0, 32'sd140552476, 1'b0, 32'sd116235963, 32'sd67108864, 32'sd0, 65536, 65536, 16384};
        vecs[7] = '{32'sh04000000, 32'sh08000000, 32'sh01000000, 1'b1, 32'sd150059982, 32'sd0, 32'sd313975187, 65536, 65536, 65536};

        sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0; in_mode = 1'b0;

        // Reset and idle state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", cur_ready, 1, 0);
        check("idle_out_valid", cur_valid, 0, 0);
        check("idle_out_x", cur_x, 0, 0);
        check("idle_out_y", cur_y, 0, 0);
        check("idle_out_z", cur_z, 0, 0);
        rst_n = 1'b0;
        #1;
        check("in_ready_during_reset", cur_ready, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Vector table on the ITER=16 instance
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].m, rx, ry, rz, lat, rdy);
            model(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].m, 16, mx, my, mz);
            check($sformatf("v%0d_latency", v), lat, 17, 0);
            check($sformatf("v%0d_x", v), rx, vecs[v].ex, vecs[v].tx);
            check($sformatf("v%0d_y", v), ry, vecs[v].ey, vecs[v].ty);
            check($sformatf("v%0d_z", v), rz, vecs[v].ez, vecs[v].tz);
            check($sformatf("v%0d_x_exact", v), rx, mx, 0);
            check($sformatf("v%0d_y_exact", v), ry, my, 0);
            check($sformatf("v%0d_z_exact", v), rz, mz, 0);
            check($sformatf("v%0d_ready_after", v), rdy, 1, 0);
        end

        // Backpressure: result held for 5 cycles while a competing operand is offered
        out_ready = 1'b0;
        in_x = vecs[0].x; in_y = vecs[0].y; in_z = vecs[0].z; in_mode = vecs[0].m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = vecs[5].x; in_y = vecs[5].y; in_z = vecs[5].z; in_mode = vecs[5].m;
        guard = 0;
        while (!cur_valid && guard < 100) begin @(posedge clk); #1; guard++; end
        check("bp_latency", guard, 17, 0);
        cx = cur_x; cy = cur_y; cz = cur_z;
        model(vecs[0].x, vecs[0].y, vecs[0].z, vecs[0].m, 16, mx, my, mz);
        check("bp_first_x", cx, mx, 0);
        check("bp_first_z", cz, mz, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), cur_valid, 1, 0);
            check($sformatf("bp_hold%0d_ready", k), cur_ready, 0, 0);
            check($sformatf("bp_hold%0d_x", k), cur_x, cx, 0);
            check($sformatf("bp_hold%0d_y", k), cur_y, cy, 0);
            check($sformatf("bp_hold%0d_z", k), cur_z, cz, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", cur_valid, 0, 0);
        check("bp_release_ready", cur_ready, 1, 0);
        run_op(vecs[1].x, vecs[1].y, vecs[1].z, vecs[1].m, rx, ry, rz, lat, rdy);
        model(vecs[1].x, vecs[1].y, vecs[1].z, vecs[1].m, 16, mx, my, mz);
        check("bp_second_latency", lat, 17, 0);
        check("bp_second_x", rx, mx, 0);
        check("bp_second_y", ry, my, 0);
        check("bp_second_z", rz, mz, 0);

        // Reset in the middle of the iterations
        in_x = vecs[2].x; in_y = vecs[2].y; in_z = vecs[2].z; in_mode = vecs[2].m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrst_busy", cur_ready, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ready", cur_ready, 1, 0);
        check("midrst_valid", cur_valid, 0, 0);
        check("midrst_out_x", cur_x, 0, 0);
        saw = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (cur_valid) saw = 1'b1; end
        check("midrst_no_result", saw, 0, 0);
        run_op(vecs[3].x, vecs[3].y, vecs[3].z, vecs[3].m, rx, ry, rz, lat, rdy);
        model(vecs[3].x, vecs[3].y, vecs[3].z, vecs[3].m, 16, mx, my, mz);
        check("midrst_next_latency", lat, 17, 0);
        check("midrst_next_x", rx, mx, 0);
        check("midrst_next_y", ry, my, 0);

        // ITER=1: one step takes (1,0) to (1,1) with z=-atan(1), then scaled by K
        sel = 2'd1;
        run_op(32'sh10000000, 32'sd0, 32'sd0, 1'b0, rx, ry, rz, lat, rdy);
        model(32'sh10000000, 32'sd0, 32'sd0, 1'b0, 1, mx, my, mz);
        check("i1_latency", lat, 2, 0);
        check("i1_x", rx, 32'sh09B74EDA, 0);
        check("i1_y", ry, 32'sh09B74EDA, 0);
        check("i1_z", rz, -32'sd210828714, 0);
        check("i1_x_exact", rx, mx, 0);
        check("i1_ready_after", rdy, 1, 0);

        // ITER=28: gain-corrected magnitude returns to 1.0
        sel = 2'd2;
        run_op(32'sh10000000, 32'sd0, 32'sd0, 1'b0, rx, ry, rz, lat, rdy);
        model(32'sh10000000, 32'sd0, 32'sd0, 1'b0, 28, mx, my, mz);
        check("i28_latency", lat, 29, 0);
        check("i28_x", rx, 32'sh10000000, 65536);
        check("i28_y", ry, 0, 65536);
        check("i28_x_exact", rx, mx, 0);
        check("i28_y_exact", ry, my, 0);
        check("i28_z_exact", rz, mz, 0);
        check("i28_ready_after", rdy, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_seq.md
Name: cordic_seq

Overview:
Iterative, multi-cycle CORDIC engine that executes one micro-rotation per clock, in place of a fully unrolled combinational chain. It supports rotation mode (drive Z to 0) and vectoring mode (drive Y to 0). Operands arrive and results leave over valid/ready handshakes. An internal FSM sequences iterations and a final gain-correction cycle. It sits between an operand-issuing master and a result consumer.

Parameters:
N, 32, data width; all X/Y/Z values are signed Q4.28 when N=32.
ITER, 16, micro-rotations per operation; legal range 1..28, elaboration error outside this range.
FRAC, 28, fractional bits of X/Y/Z and of the atan/K constants.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand valid
in_ready  out  1  block can accept an operand
in_x  in  N  signed X operand
in_y  in  N  signed Y operand
in_z  in  N  signed Z operand, angle in radians
in_mode  in  1  0 = rotation, 1 = vectoring
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_x  out  N  gain-corrected X
out_y  out  N  gain-corrected Y
out_z  out  N  residual Z (rotation) or accumulated angle (vectoring); not gain-corrected

Behaviour:
- Clocking and reset, as decided: one clock, clk; reset rst_n is synchronous and active-low.
- While rst_n=0 at a clk edge: state<=IDLE, cnt<=0, out_valid<=0, out_x/out_y/out_z<=0, working X/Y/Z regs<=0.
- Reset applies mid-operation too. The in-flight operand is discarded and no out_valid is produced for it.
- in_ready = (state==IDLE) && rst_n. It is combinational from the state.
- States and transitions:
  - IDLE: on in_valid&&in_ready, latch operands and mode, cnt<=0, go to ITER.
  - ITER: each edge performs iteration i=cnt, then cnt<=cnt+1. When i==ITER-1, go to SCALE.
  - SCALE: out_x<=(X*K)>>>FRAC, out_y<=(Y*K)>>>FRAC, out_z<=Z. Set out_valid<=1 and go to DONE.
  - DONE: outputs and out_valid held stable until out_valid&&out_ready; then out_valid<=0 and go to IDLE.
- Latency: out_valid rises exactly ITER+1 clk edges after the accepting edge. in_ready returns 1 on the cycle after the output handshake.
- Throughput: at most one operation per ITER+3 cycles. There is no overlap and no same-cycle accept in DONE.
- Iteration i, with d=+1 or -1:
  - rotation mode: d=+1 iff Z>=0 (sign bit 0);
  - vectoring mode: d=+1 iff Y<0.
  - X'=X-d*(Y>>>i); Y'=Y+d*(X>>>i); Z'=Z-d*ATAN[i].
- Arithmetic rules:
  - Shifts are arithmetic.
  - Add/sub wraps two's-complement modulo 2^N, with no saturation.
  - The scale product is a full 2N-bit signed product, arithmetic-shifted right by FRAC, then truncated to the low N bits.
- K=0x09B74EDA (0.6072529350, Q4.28) is fixed regardless of ITER. Residual gain error for small ITER is accepted.
- Convergence domain:
  - rotation: |in_z| <= 1.7433 rad;
  - vectoring: in_x > 0.
  - Outside this domain the result is whatever the arithmetic yields. There is no error flag.
- in_* are ignored outside the IDLE accept cycle. out_ready is ignored when out_valid=0.

Decomposition:
- Package cordic_pkg contains:
  - ATAN[0:27]: atan(2^-i) in Q4.28; ATAN[0]=0x0C90FDAA, ATAN[1]=0x076B19C1, …;
  - K_GAIN=0x09B74EDA;
  - MODE_ROT=0, MODE_VEC=1;
  - state enum {IDLE, ITER, SCALE, DONE}.
- One sub-module, cordic_iter_step: combinational single micro-rotation. Inputs are X, Y, Z, i, mode, atan_i; outputs are X', Y', Z'. It is instantiated once and time-shared by the FSM.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, outputs all 0.
- Rotation with in_x=0x10000000 (1.0), in_y=0, in_z=0x0C90FDAA (pi/4), ITER=16 -> out_valid exactly 17 edges after accept; out_x and out_y each 0x0B504F33 ±2^-12; |out_z| < 2^-14.
- Vectoring with in_x=0x0999999A (0.6), in_y=0x0CCCCCCD (0.8), ITER=16 -> out_z = 248918915 ±2^-12 scaled (0.92730 rad); out_x = 0x10000000 ±2^-12; |out_y| < 2^-12.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_* and out_valid stable, in_ready=0; release -> handshake, in_ready=1 on the next cycle; a second operand is accepted and completes correctly.
- Reset mid-ITER: assert rst_n=0 for 1 cycle at cnt=7 -> state IDLE, out_valid never asserts for that operand; next operand completes with the nominal latency.
- Mode/ITER sweep: ITER=1 and ITER=28 builds; in_z=0 rotation of (1.0, 0) -> out_x ≈ 1.0*K*An(ITER), matching a bit-exact reference model.
